// File: rtl/pid_pkg.sv
// Shared defaults and helpers for the PID controller datapath.
package pid_pkg;

  localparam int ERR_W   = 10;
  localparam int DIFF_W  = 7;
  localparam int COEFF_W = 6;

  // Clamp a signed value into the range of a w-bit two's-complement number.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] val,
                                                    input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (val > hi)      return hi;
    else if (val < lo) return lo;
    else               return val;
  endfunction

endpackage

// File: rtl/pid_d_term_d_hist.sv
// Error history shift register. Advances only on accepted samples and
// counts fill up to DEPTH so the consumer knows when the oldest tap is real.
module d_hist #(
  parameter int ERR_W = 10,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    accept,
  input  logic signed [ERR_W-1:0] din,
  output logic signed [ERR_W-1:0] oldest,
  output logic                    primed
);
  import pid_pkg::*;

  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);

  logic signed [ERR_W-1:0] hist [DEPTH];
  logic [FILL_W-1:0]       fill;

  // Shift in accepted samples; clr and reset empty the history.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      fill <= '0;
    end else if (accept) begin
      hist[0] <= din;
      for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
      if (fill != FULL) fill <= fill + 1'b1;
    end
  end

  assign oldest = hist[DEPTH-1];
  assign primed = (fill == FULL);

endmodule

// File: rtl/pid_d_term.sv
// Derivative term: difference against the sample D_DEPTH accepts back,
// saturated and scaled by a runtime coefficient over two pipeline stages.
// Output is forced to zero until the history has filled, to avoid a
// derivative kick right after reset or a mode change.
module pid_d_term #(
  parameter int ERR_W   = pid_pkg::ERR_W,
  parameter int DIFF_W  = pid_pkg::DIFF_W,
  parameter int COEFF_W = pid_pkg::COEFF_W,
  parameter int D_DEPTH = 2,
  localparam int D_W    = DIFF_W + COEFF_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [ERR_W-1:0] err_sat,
  input  logic                    err_vld,
  input  logic [COEFF_W-1:0]      d_coeff,
  input  logic                    clr,
  output logic signed [D_W-1:0]   D_term,
  output logic                    D_vld,
  output logic                    primed
);
  import pid_pkg::*;

  if (D_DEPTH < 1 || D_DEPTH > 16) begin : g_depth_check
    $error("pid_d_term: D_DEPTH must be in 1..16");
  end

  logic                     accept;
  logic signed [ERR_W-1:0]  oldest;
  logic signed [ERR_W:0]    diff;
  logic signed [DIFF_W-1:0] diff_sat;

  logic signed [DIFF_W-1:0] s1_diff;
  logic [COEFF_W-1:0]       s1_coeff;
  logic                     s1_zero;
  logic                     s1_vld;

  logic signed [D_W-1:0]    mul_a;
  logic signed [D_W-1:0]    mul_b;
  logic signed [D_W-1:0]    product;

  assign accept = err_vld && !clr;

  d_hist #(
    .ERR_W (ERR_W),
    .DEPTH (D_DEPTH)
  ) u_hist (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .accept (accept),
    .din    (err_sat),
    .oldest (oldest),
    .primed (primed)
  );

  // One extra bit of headroom means the subtraction can never wrap.
  assign diff     = {err_sat[ERR_W-1], err_sat} - {oldest[ERR_W-1], oldest};
  assign diff_sat = DIFF_W'(sat_signed(32'(diff), DIFF_W));

  // Stage 1: capture saturated diff, the coefficient of the accept cycle,
  // and whether this sample arrived before the history was full.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      s1_diff  <= '0;
      s1_coeff <= '0;
      s1_zero  <= 1'b0;
      s1_vld   <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_diff  <= diff_sat;
        s1_coeff <= d_coeff;
        s1_zero  <= !primed;
      end
    end
  end

  // Coefficient is unsigned; a zero MSB keeps it positive in the signed product.
  assign mul_a   = D_W'(s1_diff);
  assign mul_b   = D_W'($signed({1'b0, s1_coeff}));
  assign product = mul_a * mul_b;

  // Stage 2: register the scaled term; it holds between strobes.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      D_term <= '0;
      D_vld  <= 1'b0;
    end else begin
      D_vld <= s1_vld;
      if (s1_vld) D_term <= s1_zero ? '0 : product;
    end
  end

endmodule

// File: tb/tb_pid_d_term.sv
// Scoreboarded bench for pid_d_term (default widths, depth 2) plus a
// depth-4 / 12-bit instance for the parametrised build.
module tb_pid_d_term;
  localparam int DEPTH = 2;
  localparam int DW    = 13;

  logic                 clk;
  logic                 rst_n;
  logic signed [9:0]    err_sat;
  logic signed [11:0]   err_sat4;
  logic                 err_vld;
  logic [5:0]           d_coeff;
  logic                 clr;
  logic signed [DW-1:0] D_term;
  logic                 D_vld;
  logic                 primed;
  logic signed [DW-1:0] D_term4;
  logic                 D_vld4;
  logic                 primed4;

  pid_d_term dut (
    .clk(clk), .rst_n(rst_n), .err_sat(err_sat), .err_vld(err_vld),
    .d_coeff(d_coeff), .clr(clr), .D_term(D_term), .D_vld(D_vld), .primed(primed)
  );

  pid_d_term #(.ERR_W(12), .D_DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .err_sat(err_sat4), .err_vld(err_vld),
    .d_coeff(d_coeff), .clr(clr), .D_term(D_term4), .D_vld(D_vld4), .primed(primed4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; int val; } exp_t;
  exp_t q[$];
  exp_t e;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mhist [DEPTH];
  int mfill  = 0;
  int mlast  = 0;

  // Apply one cycle of inputs, update the reference model, advance to the
  // next falling edge. No comparisons here.
  task automatic drive_cycle(input bit vld, input int err, input int coeff, input bit c);
    int d;
    err_vld  = vld;
    err_sat  = 10'(err);
    err_sat4 = 12'(err);
    d_coeff  = 6'(coeff);
    clr      = c;
    if (!rst_n || c) begin
      for (int i = 0; i < DEPTH; i++) mhist[i] = 0;
      mfill = 0;
      q.delete();
      mlast = 0;
    end else if (vld) begin
      d = err - mhist[DEPTH-1];
      if (d > 63) d = 63;
      else if (d < -64) d = -64;
      e.due = cyc + 2;
      e.val = (mfill < DEPTH) ? 0 : d * coeff;
      q.push_back(e);
      for (int i = DEPTH - 1; i > 0; i--) mhist[i] = mhist[i-1];
      mhist[0] = err;
      if (mfill < DEPTH) mfill++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) begin
      drive_cycle(1, 100, 5, 0);
      checks++; if (D_term !== '0)  begin errors++; $display("FAIL reset_dterm got=%0d exp=0", D_term); end
      checks++; if (D_vld !== 1'b0) begin errors++; $display("FAIL reset_dvld got=%b exp=0", D_vld); end
      checks++; if (primed !== 1'b0) begin errors++; $display("FAIL reset_primed got=%b exp=0", primed); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_warmup();
    int s[6] = '{10, 20, 30, 0, 0, 0};
    for (int k = 0; k < 6; k++) begin
      drive_cycle(k < 3, s[k], 11, 0);
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front(); mlast = e.val;
        checks++; if (D_vld !== 1'b1) begin errors++; $display("FAIL warmup_vld cyc=%0d got=%b exp=1", cyc, D_vld); end
      end else begin
        checks++; if (D_vld !== 1'b0) begin errors++; $display("FAIL warmup_vld cyc=%0d got=%b exp=0", cyc, D_vld); end
      end
      checks++; if (D_term !== DW'(mlast)) begin errors++; $display("FAIL warmup_dterm cyc=%0d got=%0d exp=%0d", cyc, D_term, mlast); end
      checks++; if (primed !== (mfill == DEPTH)) begin errors++; $display("FAIL warmup_primed cyc=%0d got=%b exp=%b", cyc, primed, mfill == DEPTH); end
    end
    checks++; if (D_term !== 13'sd220) begin errors++; $display("FAIL warmup_final got=%0d exp=220", D_term); end
  endtask

  task automatic test_pos_sat();
    int s[6] = '{-512, -512, 511, 0, 0, 0};
    for (int k = 0; k < 6; k++) begin
      drive_cycle(k < 3, s[k], 11, 0);
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front(); mlast = e.val;
        checks++; if (D_vld !== 1'b1) begin errors++; $display("FAIL possat_vld cyc=%0d got=%b exp=1", cyc, D_vld); end
      end else begin
        checks++; if (D_vld !== 1'b0) begin errors++; $display("FAIL possat_vld cyc=%0d got=%b exp=0", cyc, D_vld); end
      end
      checks++; if (D_term !== DW'(mlast)) begin errors++; $display("FAIL possat_dterm cyc=%0d got=%0d exp=%0d", cyc, D_term, mlast); end
    end
    checks++; if (D_term !== 13'sd693) begin errors++; $display("FAIL possat_final got=%0d exp=693", D_term); end
  endtask

  task automatic test_neg_extreme();
    int s[5] = '{511, -512, 0, 0, 0};
    for (int k = 0; k < 5; k++) begin
      drive_cycle(k < 2, s[k], 63, 0);
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front(); mlast = e.val;
        checks++; if (D_vld !== 1'b1) begin errors++; $display("FAIL negext_vld cyc=%0d got=%b exp=1", cyc, D_vld); end
      end else begin
        checks++; if (D_vld !== 1'b0) begin errors++; $display("FAIL negext_vld cyc=%0d got=%b exp=0", cyc, D_vld); end
      end
      checks++; if (D_term !== DW'(mlast)) begin errors++; $display("FAIL negext_dterm cyc=%0d got=%0d exp=%0d", cyc, D_term, mlast); end
    end
    checks++; if (D_term !== -13'sd4032) begin errors++; $display("FAIL negext_final got=%0d exp=-4032", D_term); end
  endtask

  task automatic test_clr();
    bit v[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    bit c[8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    int s[8] = '{100, 300, 0, 0, 5, 7, 0, 0};
    for (int k = 0; k < 8; k++) begin
      drive_cycle(v[k], s[k], 40, c[k]);
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front(); mlast = e.val;
        checks++; if (D_vld !== 1'b1) begin errors++; $display("FAIL clr_vld cyc=%0d got=%b exp=1", cyc, D_vld); end
      end else begin
        checks++; if (D_vld !== 1'b0) begin errors++; $display("FAIL clr_vld cyc=%0d got=%b exp=0", cyc, D_vld); end
      end
      checks++; if (D_term !== DW'(mlast)) begin errors++; $display("FAIL clr_dterm cyc=%0d got=%0d exp=%0d", cyc, D_term, mlast); end
      checks++; if (primed !== (mfill == DEPTH)) begin errors++; $display("FAIL clr_primed cyc=%0d got=%b exp=%b", cyc, primed, mfill == DEPTH); end
      if (k == 2) begin
        checks++; if (primed !== 1'b0) begin errors++; $display("FAIL clr_unprimed got=%b exp=0", primed); end
      end
    end
  endtask

  task automatic test_gap();
    bit v[9] = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
    int s[9] = '{50, 0, 0, 0, 80, 0, 0, 0, 0};
    int c[9] = '{10, 10, 20, 20, 20, 20, 20, 20, 20};
    for (int k = 0; k < 9; k++) begin
      drive_cycle(v[k], s[k], c[k], 0);
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front(); mlast = e.val;
        checks++; if (D_vld !== 1'b1) begin errors++; $display("FAIL gap_vld cyc=%0d got=%b exp=1", cyc, D_vld); end
      end else begin
        checks++; if (D_vld !== 1'b0) begin errors++; $display("FAIL gap_vld cyc=%0d got=%b exp=0", cyc, D_vld); end
      end
      checks++; if (D_term !== DW'(mlast)) begin errors++; $display("FAIL gap_dterm cyc=%0d got=%0d exp=%0d", cyc, D_term, mlast); end
      if (k == 3) begin
        checks++; if (D_term !== 13'sd450) begin errors++; $display("FAIL gap_hold got=%0d exp=450", D_term); end
      end
    end
    checks++; if (D_term !== 13'sd1260) begin errors++; $display("FAIL gap_newcoeff got=%0d exp=1260", D_term); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 300; k++) begin
      drive_cycle(k < 290 && $urandom_range(0, 3) != 0, int'($urandom_range(0, 1023)) - 512,
                  int'($urandom_range(0, 63)), k < 290 && $urandom_range(0, 24) == 0);
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front(); mlast = e.val;
        checks++; if (D_vld !== 1'b1) begin errors++; $display("FAIL b2b_vld cyc=%0d got=%b exp=1", cyc, D_vld); end
      end else begin
        checks++; if (D_vld !== 1'b0) begin errors++; $display("FAIL b2b_vld cyc=%0d got=%b exp=0", cyc, D_vld); end
      end
      checks++; if (D_term !== DW'(mlast)) begin errors++; $display("FAIL b2b_dterm cyc=%0d got=%0d exp=%0d", cyc, D_term, mlast); end
      checks++; if (primed !== (mfill == DEPTH)) begin errors++; $display("FAIL b2b_primed cyc=%0d got=%b exp=%b", cyc, primed, mfill == DEPTH); end
    end
  endtask

  task automatic test_depth4();
    bit v[8] = '{0, 1, 1, 1, 1, 1, 0, 0};
    bit c[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    int s[8] = '{0, 100, 200, 300, 400, 500, 0, 0};
    for (int k = 0; k < 8; k++) begin
      drive_cycle(v[k], s[k], 1, c[k]);
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front(); mlast = e.val;
        checks++; if (D_vld !== 1'b1) begin errors++; $display("FAIL d4_main_vld cyc=%0d got=%b exp=1", cyc, D_vld); end
      end else begin
        checks++; if (D_vld !== 1'b0) begin errors++; $display("FAIL d4_main_vld cyc=%0d got=%b exp=0", cyc, D_vld); end
      end
      checks++; if (D_term !== DW'(mlast)) begin errors++; $display("FAIL d4_main_dterm cyc=%0d got=%0d exp=%0d", cyc, D_term, mlast); end
      if (k == 3) begin
        checks++; if (primed4 !== 1'b0) begin errors++; $display("FAIL d4_primed_early got=%b exp=0", primed4); end
      end
      if (k == 4) begin
        checks++; if (primed4 !== 1'b1) begin errors++; $display("FAIL d4_primed got=%b exp=1", primed4); end
      end
      if (k == 6) begin
        checks++; if (D_vld4 !== 1'b1) begin errors++; $display("FAIL d4_vld got=%b exp=1", D_vld4); end
      end
    end
    checks++; if (D_term4 !== 13'sd63) begin errors++; $display("FAIL d4_dterm got=%0d exp=63", D_term4); end
  endtask

  initial begin
    rst_n   = 1'b0;
    err_vld = 1'b0;
    err_sat = '0;
    err_sat4 = '0;
    d_coeff = '0;
    clr     = 1'b0;
    for (int i = 0; i < DEPTH; i++) mhist[i] = 0;
    @(negedge clk);
    test_reset();
    test_warmup();
    test_pos_sat();
    test_neg_extreme();
    test_clr();
    test_gap();
    test_back_to_back();
    test_depth4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
